cpu_seq_ctrl: RTL and testbench

- Parametrised multi-cycle sequencer for the CPU datapath; next generation of the existing fixed-timing control FSM.
- Generates PC/IR/register-file/flag/link/memory strobes per instruction class.
- Adds variable-latency memory handshake (req/ack), ack timeout with trap, HALT, single-step debug mode and a retired-instruction counter.
- Sits between the decoder (instruction class in) and the datapath muxes/enables (strobes out).

---
 rtl/cpu_seq_pkg.sv | 23 ++
 rtl/cpu_seq_wait_timer.sv | 20 ++
 rtl/cpu_seq_ctrl.sv | 89 ++++++++
 tb/tb_cpu_seq_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: instruction class encodings and sequencer state encoding
package cpu_seq_pkg;
  typedef enum logic [2:0] {
    C_ALU_R   = 3'd0,
    C_ALU_I   = 3'd1,
    C_LOAD    = 3'd2,
    C_STORE   = 3'd3,
    C_BRANCH  = 3'd4,
    C_JAL     = 3'd5,
    C_ILLEGAL = 3'd6,
    C_HALT    = 3'd7
  } cls_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALTED,
    S_PAUSE,
    S_TRAP
  } state_e;
endpackage

// File: rtl/cpu_seq_wait_timer.sv
// cpu_seq_wait_timer: counts memory wait cycles and flags an ack timeout
module cpu_seq_wait_timer #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ack,
  output logic timeout
);
  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  logic [TO_W-1:0] cnt;
  // count unacknowledged request cycles; idle cycles and acks leave it at zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (active && !ack) ? cnt + TO_W'(1) : '0;
  // an ack in the limit cycle suppresses the timeout
  assign timeout = (TIMEOUT != 0) && active && !ack && (cnt == LIMIT);
endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle instruction sequencer driving datapath strobes
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int TYPE_W  = 3,
  parameter int CNT_W   = 32,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TYPE_W-1:0] instr_type,
  input  logic              mem_ack,
  input  logic              step_mode,
  input  logic              resume,
  output logic              mem_req,
  output logic              mem_we,
  output logic              reg_read,
  output logic              ir_enable,
  output logic              pc_enable,
  output logic              r_enable,
  output logic              alu_bus_enable,
  output logic              link_en,
  output logic              flags_enable,
  output logic              halted,
  output logic              trap,
  output logic [CNT_W-1:0]  retired
);
  state_e state, state_n;
  cls_e cls, cls_in;
  logic timeout, exec_alu, exec_jal, mem_done;
  assign cls_in = cls_e'(instr_type[2:0]);
  cpu_seq_wait_timer #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .active (mem_req),
    .ack    (mem_ack),
    .timeout(timeout)
  );
  // state register; reset drops any outstanding request immediately
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= state_n;
  // class is captured in DECODE so EXEC/MEM strobes do not depend on the decoder holding it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cls     <= C_ALU_R;
      retired <= '0;
    end else begin
      if (state == S_DECODE) cls <= cls_in;
      if (pc_enable) retired <= retired + CNT_W'(1);
    end
  // next-state selection; ack beats timeout, TRAP only leaves via reset
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   state_n = S_FETCH;
      S_FETCH:  state_n = mem_ack ? S_DECODE : timeout ? S_TRAP : S_FETCH;
      S_DECODE:
        case (cls_in)
          C_LOAD, C_STORE: state_n = S_MEM;
          C_HALT:          state_n = S_HALTED;
          C_ILLEGAL:       state_n = S_TRAP;
          default:         state_n = S_EXEC;
        endcase
      S_EXEC:   state_n = step_mode ? S_PAUSE : S_FETCH;
      S_MEM:    state_n = mem_ack ? (step_mode ? S_PAUSE : S_FETCH) : timeout ? S_TRAP : S_MEM;
      S_HALTED, S_PAUSE: state_n = resume ? S_FETCH : state;
      default:  state_n = S_TRAP;
    endcase
  end
  // strobes decoded from state, latched class and mem_ack
  always_comb begin
    exec_alu       = state == S_EXEC && (cls == C_ALU_R || cls == C_ALU_I);
    exec_jal       = state == S_EXEC && cls == C_JAL;
    mem_done       = state == S_MEM && mem_ack;
    mem_req        = state == S_FETCH || state == S_MEM;
    reg_read       = state == S_MEM;
    mem_we         = state == S_MEM && cls == C_STORE;
    ir_enable      = state == S_FETCH && mem_ack;
    pc_enable      = state == S_EXEC || mem_done;
    r_enable       = exec_alu || exec_jal || (mem_done && cls == C_LOAD);
    alu_bus_enable = exec_alu;
    link_en        = exec_jal;
    flags_enable   = exec_alu;
    halted         = state == S_HALTED || state == S_PAUSE || state == S_TRAP;
    trap           = state == S_TRAP;
  end
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: scoreboard bench for the instruction sequencer
module tb_cpu_seq_ctrl;
  import cpu_seq_pkg::*;
  localparam int TMO = 6;
  localparam logic [10:0] REQ = 11'h400, WE = 11'h200, RD = 11'h100, IR = 11'h080,
                          PC = 11'h040, RE = 11'h020, ALU = 11'h010, LNK = 11'h008,
                          FL = 11'h004, HLT = 11'h002, TRP = 11'h001;
  logic clk = 0, reset = 0, mem_ack = 0, step_mode = 0, resume = 0;
  logic [2:0] instr_type = '0;
  logic mem_req, mem_we, reg_read, ir_enable, pc_enable, r_enable;
  logic alu_bus_enable, link_en, flags_enable, halted, trap;
  logic [31:0] retired;
  logic [10:0] obs;
  typedef struct { logic [10:0] s; logic [31:0] r; string nm; } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  logic [31:0] rcnt = '0;

  assign obs = {mem_req, mem_we, reg_read, ir_enable, pc_enable, r_enable,
                alu_bus_enable, link_en, flags_enable, halted, trap};

  always #5 clk = ~clk;

  cpu_seq_ctrl #(.TYPE_W(3), .CNT_W(32), .TO_W(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .instr_type(instr_type), .mem_ack(mem_ack),
    .step_mode(step_mode), .resume(resume), .mem_req(mem_req), .mem_we(mem_we),
    .reg_read(reg_read), .ir_enable(ir_enable), .pc_enable(pc_enable),
    .r_enable(r_enable), .alu_bus_enable(alu_bus_enable), .link_en(link_en),
    .flags_enable(flags_enable), .halted(halted), .trap(trap), .retired(retired)
  );

  always @(negedge clk)
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (obs !== e.s || retired !== e.r) begin
        errors++;
        $display("FAIL %s: got strobes=%b retired=%0d, want strobes=%b retired=%0d",
                 e.nm, obs, retired, e.s, e.r);
      end
    end

  task automatic cyc(input logic [2:0] ty, input logic ack, input logic res,
                     input logic [10:0] s, input string nm);
    @(posedge clk);
    #1;
    instr_type = ty;
    mem_ack    = ack;
    resume     = res;
    q.push_back('{s, rcnt, nm});
    if (s[6]) rcnt++;
  endtask

  task automatic chk_now(input string nm);
    checks++;
    if (obs !== 11'h0 || retired !== 32'd0) begin
      errors++;
      $display("FAIL %s: got strobes=%b retired=%0d, want strobes=%b retired=0",
               nm, obs, retired, 11'h0);
    end
  endtask

  task automatic rst_pulse(input string nm, input int dly);
    @(posedge clk);
    #(dly);
    reset = 0;
    #1;
    chk_now(nm);
    rcnt = '0;
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic run3(input logic [2:0] ty, input logic [10:0] ex, input string nm);
    cyc(ty, 1, 0, REQ | IR, {nm, "_fetch"});
    cyc(ty, 1, 0, 11'h0, {nm, "_decode"});
    cyc(ty, 1, 0, ex, {nm, "_exec"});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_now("reset_state");
    reset = 1;
    run3(C_ALU_R, PC | RE | ALU | FL, "alu_r");
    run3(C_ALU_I, PC | RE | ALU | FL, "alu_i");
    cyc(C_BRANCH, 1, 0, REQ | IR, "br_fetch");
    cyc(C_BRANCH, 1, 1, 11'h0, "br_decode_resume_ignored");
    cyc(C_BRANCH, 1, 0, PC, "br_exec");
    run3(C_JAL, PC | RE | LNK, "jal");
    cyc(C_LOAD, 1, 0, REQ | IR, "ld_fetch_retired4");
    cyc(C_LOAD, 0, 0, 11'h0, "ld_decode");
    for (int i = 0; i < 4; i++) cyc(C_LOAD, 0, 0, REQ | RD, "ld_wait");
    cyc(C_LOAD, 1, 0, REQ | RD | RE | PC, "ld_ack");
    for (int i = 0; i < TMO - 1; i++) cyc(C_BRANCH, 0, i == 2, REQ, "fetch_wait");
    cyc(C_BRANCH, 1, 0, REQ | IR, "fetch_ack_at_limit");
    cyc(C_BRANCH, 0, 0, 11'h0, "fetch_limit_decode");
    cyc(C_BRANCH, 0, 0, PC, "fetch_limit_exec");
    for (int k = 0; k < 3; k++) begin
      cyc(C_ALU_R, 1, 0, REQ | IR, "step_fetch");
      step_mode = 1;
      cyc(C_ALU_R, 1, 0, 11'h0, "step_decode");
      cyc(C_ALU_R, 1, 0, PC | RE | ALU | FL, "step_exec");
      cyc(C_ALU_R, 0, 0, HLT, "step_pause");
      cyc(C_ALU_R, 0, 1, HLT, "step_pause_resume");
    end
    step_mode = 0;
    cyc(C_HALT, 1, 0, REQ | IR, "halt_fetch_retired9");
    cyc(C_HALT, 0, 0, 11'h0, "halt_decode");
    cyc(C_HALT, 0, 0, HLT, "halted");
    cyc(C_HALT, 0, 1, HLT, "halted_resume");
    cyc(C_STORE, 1, 0, REQ | IR, "st_fetch_retired9");
    cyc(C_STORE, 0, 0, 11'h0, "st_decode");
    for (int i = 0; i < TMO; i++) cyc(C_STORE, 0, 0, REQ | WE | RD, "st_wait");
    cyc(C_STORE, 0, 1, HLT | TRP, "st_trap_resume_ignored");
    cyc(C_STORE, 0, 0, HLT | TRP, "st_trap_sticky");
    rst_pulse("trap_cleared_by_reset", 1);
    cyc(C_ILLEGAL, 1, 0, REQ | IR, "ill_fetch");
    cyc(C_ILLEGAL, 0, 0, 11'h0, "ill_decode");
    cyc(C_ILLEGAL, 0, 0, HLT | TRP, "ill_trap");
    rst_pulse("ill_trap_cleared", 1);
    run3(C_ALU_R, PC | RE | ALU | FL, "pre_async");
    cyc(C_ALU_R, 0, 0, REQ, "async_fetch_wait");
    cyc(C_ALU_R, 0, 0, REQ, "async_fetch_wait");
    rst_pulse("async_reset_mid_fetch", 3);
    cyc(C_ALU_R, 1, 0, REQ | IR, "post_reset_fetch");
    cyc(C_ALU_R, 1, 0, 11'h0, "post_reset_decode");
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
